// File: rtl/deserializador_bc.sv
// Comma-aligned serial-to-parallel receiver: hunts for the COMMA symbol at any
// bit offset, confirms alignment over LOCK_CNT bytes, then emits data bytes.
module deserializador_bc #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned LCW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [LCW-1:0]   lock_q, lock_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;

  logic [7:0]       cand;
  logic             isComma;
  logic             byteDone;
  logic [LCW-1:0]   lockInc;

  // The byte under test includes the bit arriving on this edge, so alignment
  // and data capture happen with no extra pipeline stage.
  always_comb begin
    cand     = {sr_q[6:0], data_in};
    isComma  = (cand == COMMA);
    byteDone = (cnt_q == 3'd7);
    lockInc  = lock_q + LCW'(1);

    state_d  = state_q;
    sr_d     = cand;
    cnt_d    = cnt_q + 3'd1;
    lock_d   = lock_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    active_d = active_q;

    case (state_q)
      HUNT: begin
        if (isComma) begin
          cnt_d  = 3'd0;
          lock_d = LCW'(1);
          if (LOCK_CNT <= 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (byteDone) begin
          if (isComma) begin
            lock_d = lockInc;
            if (lockInc >= LCW'(LOCK_CNT)) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d = HUNT;
            lock_d  = '0;
          end
        end
      end

      ACTIVE: begin
        // Commas on the byte boundary are idle fill and leave data_out alone.
        if (byteDone && !isComma) begin
          data_d  = cand;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      sr_q     <= 8'h00;
      cnt_q    <= 3'd0;
      lock_q   <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      lock_q   <= lock_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule
